seq_shifter: RTL and testbench



---
 rtl/seq_shifter.sv | 95 +++++++++
 tb/tb_seq_shifter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - iterative shifter, one bit position per clock, done strobe on completion
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] out_q;
    logic [SHW-1:0]   cnt_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             busy_q;
    logic             done_q;

    // One-bit step; mode 11 falls through to the logical case.
    always_comb begin
        data_d = data_q;
        if (dir_q) begin
            if (mode_q == MODE_ROT) begin
                data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            end else begin
                data_d = {data_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mode_q == MODE_ARITH) begin
                data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            end else if (mode_q == MODE_ROT) begin
                data_d = {data_q[0], data_q[WIDTH-1:1]};
            end else begin
                data_d = {1'b0, data_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            data_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    data_q  <= in;
                    cnt_q   <= shamt;
                    dir_q   <= dir;
                    mode_q  <= mode;
                    busy_q  <= 1'b1;
                    state_q <= SHIFT;
                end
            end else begin
                // A zero count still spends one cycle here so shamt=0 yields a done pulse.
                if (cnt_q != '0) begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - SHW'(1);
                end else begin
                    out_q   <= data_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - randomized self-checking bench for seq_shifter against an arithmetic model
module tb_seq_shifter;
    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] op_in;
    logic [2:0] op_shamt;
    logic       op_dir;
    logic [1:0] op_mode;
    logic       busy;
    logic       done;
    logic [7:0] out_w;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(8), .SHW(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .start(start),
        .in   (op_in),
        .shamt(op_shamt),
        .dir  (op_dir),
        .mode (op_mode),
        .busy (busy),
        .done (done),
        .out  (out_w)
    );

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input int s,
                                              input logic d, input logic [1:0] m);
        int v;
        int r;
        v = int'(a);
        if (m == 2'b10) begin
            if (d) r = (v << s) | (v >> (8 - s));
            else   r = (v >> s) | (v << (8 - s));
        end else if (d) begin
            r = v << s;
        end else if (m == 2'b01) begin
            r = ((v >= 128) ? v - 256 : v) >>> s;
        end else begin
            r = v >> s;
        end
        return 8'(r & 255);
    endfunction

    // Issues one job; reports latency in edges after accept (-1 on timeout), result,
    // busy/done status sanity, out hold during the job, and whether done fell afterwards.
    task automatic run_op(input logic [7:0] a, input logic [2:0] s, input logic d,
                          input logic [1:0] m, input int inject_at,
                          output int lat, output logic [7:0] res, output logic status_ok,
                          output logic hold_ok, output logic pulse_ok);
        int n;
        logic [7:0] prev;
        @(negedge clk);
        op_in = a; op_shamt = s; op_dir = d; op_mode = m; start = 1'b1;
        prev = out_w;
        @(negedge clk);
        start = 1'b0;
        n = 0; lat = -1; status_ok = 1'b1; hold_ok = 1'b1;
        while (n <= 20) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) status_ok = 1'b0;
            if (out_w !== prev) hold_ok = 1'b0;
            if (n == inject_at) begin
                start = 1'b1; op_in = 8'hFF; op_shamt = 3'd7; op_dir = ~d; op_mode = ~m;
            end else if (inject_at >= 0 && n == inject_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        res = out_w;
        if (busy !== 1'b0) status_ok = 1'b0;
        @(negedge clk);
        pulse_ok = (done === 1'b0);
    endtask

    task automatic test_reset();
        int lat;
        logic [7:0] res;
        logic st, hd, pl;
        rstn = 1'b0; start = 1'b1; op_in = 8'h3C; op_shamt = 3'd2; op_dir = 1'b1; op_mode = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
        nvec++; if (out_w !== 8'h00) begin nerr++; $display("FAIL reset_out got %h want 00", out_w); end
        rstn = 1'b1; start = 1'b0;
        run_op(8'h3C, 3'd2, 1'b1, 2'b00, -1, lat, res, st, hd, pl);
        nvec++; if (res !== 8'hF0) begin nerr++; $display("FAIL post_reset_out got %h want f0", res); end
        nvec++; if (lat != 3) begin nerr++; $display("FAIL post_reset_lat got %0d want 3", lat); end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [2:0] s;
        logic       d;
        logic [1:0] m;
        logic [7:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[7];
        int lat;
        logic [7:0] res;
        logic st, hd, pl;
        tbl[0] = '{8'b01110100, 3'd3, 1'b1, 2'b00, 8'b10100000};
        tbl[1] = '{8'b01011100, 3'd5, 1'b0, 2'b00, 8'b00000010};
        tbl[2] = '{8'b10010000, 3'd2, 1'b0, 2'b01, 8'b11100100};
        tbl[3] = '{8'b10000001, 3'd1, 1'b1, 2'b10, 8'b00000011};
        tbl[4] = '{8'b10000001, 3'd1, 1'b0, 2'b10, 8'b11000000};
        tbl[5] = '{8'hA5,       3'd0, 1'b1, 2'b00, 8'hA5};
        tbl[6] = '{8'b10010000, 3'd2, 1'b0, 2'b11, 8'b00100100};
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].m, -1, lat, res, st, hd, pl);
            nvec++; if (res !== tbl[i].exp) begin nerr++; $display("FAIL dir_out[%0d] got %h want %h", i, res, tbl[i].exp); end
            nvec++; if (lat != int'(tbl[i].s) + 1) begin nerr++; $display("FAIL dir_lat[%0d] got %0d want %0d", i, lat, int'(tbl[i].s) + 1); end
            nvec++; if (!st) begin nerr++; $display("FAIL dir_busy[%0d] got bad want ok", i); end
            nvec++; if (!pl) begin nerr++; $display("FAIL dir_pulse[%0d] got long want 1cyc", i); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        logic [7:0] res;
        logic st, hd, pl;
        run_op(8'b01011100, 3'd5, 1'b0, 2'b00, 1, lat, res, st, hd, pl);
        nvec++; if (res !== 8'b00000010) begin nerr++; $display("FAIL busy_ign_out got %h want 02", res); end
        nvec++; if (lat != 6) begin nerr++; $display("FAIL busy_ign_lat got %0d want 6", lat); end
        nvec++; if (!pl) begin nerr++; $display("FAIL busy_ign_pulse got extra want none"); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [7:0] res;
        logic st, hd, pl;
        run_op(8'hA5, 3'd0, 1'b0, 2'b00, -1, lat, res, st, hd, pl);
        @(negedge clk);
        op_in = 8'h5A; op_shamt = 3'd7; op_dir = 1'b1; op_mode = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        nvec++; if (out_w !== 8'h00) begin nerr++; $display("FAIL mid_rst_out got %h want 00", out_w); end
        rstn = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        nvec++; if (seen != 0) begin nerr++; $display("FAIL mid_rst_done got %0d pulses want 0", seen); end
        run_op(8'h5A, 3'd3, 1'b1, 2'b10, -1, lat, res, st, hd, pl);
        nvec++; if (res !== 8'hD2) begin nerr++; $display("FAIL mid_rst_next got %h want d2", res); end
    endtask

    task automatic test_back_to_back();
        int n;
        int t1;
        int t2;
        logic [7:0] r1;
        logic [7:0] r2;
        logic both;
        @(negedge clk);
        op_in = 8'hC3; op_shamt = 3'd2; op_dir = 1'b1; op_mode = 2'b00; start = 1'b1;
        @(negedge clk);
        op_in = 8'h81; op_shamt = 3'd3; op_dir = 1'b0; op_mode = 2'b01;
        n = 0; t1 = -1; t2 = -1; r1 = 8'h00; r2 = 8'h00; both = 1'b0;
        while (n <= 30 && t2 < 0) begin
            if (done === 1'b1 && busy === 1'b1) both = 1'b1;
            if (t1 >= 0 && n == t1 + 1) start = 1'b0;
            if (done === 1'b1) begin
                if (t1 < 0) begin t1 = n; r1 = out_w; end
                else begin t2 = n; r2 = out_w; end
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        nvec++; if (t1 != 3) begin nerr++; $display("FAIL b2b_t1 got %0d want 3", t1); end
        nvec++; if (r1 !== 8'h0C) begin nerr++; $display("FAIL b2b_r1 got %h want 0c", r1); end
        nvec++; if (t2 != 8) begin nerr++; $display("FAIL b2b_t2 got %0d want 8", t2); end
        nvec++; if (r2 !== 8'hF0) begin nerr++; $display("FAIL b2b_r2 got %h want f0", r2); end
        nvec++; if (both) begin nerr++; $display("FAIL b2b_done_busy got both want exclusive"); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] a;
        logic [7:0] res;
        logic [7:0] exp;
        logic [2:0] s;
        logic d;
        logic [1:0] m;
        logic st, hd, pl;
        for (int k = 0; k < 364; k++) begin
            a = 8'($urandom);
            if (k < 64) begin
                s = 3'(k % 8); d = 1'((k / 8) % 2); m = 2'(k / 16);
            end else begin
                s = 3'($urandom_range(0, 7)); d = 1'($urandom); m = 2'($urandom);
            end
            exp = ref_shift(a, int'(s), d, m);
            run_op(a, s, d, m, -1, lat, res, st, hd, pl);
            nvec++; if (res !== exp) begin nerr++; $display("FAIL rnd_out a=%h s=%0d d=%b m=%b got %h want %h", a, s, d, m, res, exp); end
            nvec++; if (lat != int'(s) + 1) begin nerr++; $display("FAIL rnd_lat s=%0d got %0d want %0d", s, lat, int'(s) + 1); end
            nvec++; if (!st) begin nerr++; $display("FAIL rnd_busy s=%0d got bad want ok", s); end
            nvec++; if (!hd) begin nerr++; $display("FAIL rnd_hold s=%0d got changed want held", s); end
            nvec++; if (!pl) begin nerr++; $display("FAIL rnd_pulse s=%0d got long want 1cyc", s); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
